// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM command sequencer.
//   sel_e        : register select toward the PWM generator (none/cmp/top/cnt)
//   pwm_cmd_t    : queued command {addr, data}
//   seq_state_e  : sequencer states
//   FIFO_DEPTH_DEF : default command FIFO depth
//   step_toward  : one-count move of a 16-bit value toward a target, never
//                  overshooting and never wrapping
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CMD_W          = 18;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CMP  = 2'd1,
        SEL_TOP  = 2'd2,
        SEL_CNT  = 2'd3
    } sel_e;

    typedef struct packed {
        sel_e        addr;
        logic [15:0] data;
    } pwm_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } seq_state_e;

    // Strict compares guard both ends: cur < tgt implies cur != 16'hFFFF,
    // cur > tgt implies cur != 0, so neither branch can wrap.
    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt);
        logic [15:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 16'd1;
        end else if (cur > tgt) begin
            nxt = cur - 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_cmd_fifo.sv
// -----------------------------------------------------------------------------
// pwm_cmd_fifo
// Synchronous FIFO holding pending sequencer commands. Show-ahead read: the
// head entry is visible on rd_data whenever empty is low.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   push     in   write push_data (ignored when full or in reset)
//   push_data in  18-bit packed command
//   pop      in   drop head entry (ignored when empty or in reset)
//   rd_data  out  head entry
//   full     out  DEPTH entries stored
//   empty    out  no entries stored
// Parameter DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module pwm_cmd_fifo
    import pwm_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CMD_W-1:0]  push_data,
    input  logic              pop,
    output logic [CMD_W-1:0]  rd_data,
    output logic              full,
    output logic              empty
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a pop in the same cycle
    // does not open a slot for a push.
    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/pwm_cmd_seq.sv
// -----------------------------------------------------------------------------
// pwm_cmd_seq
// Queues register-write commands and replays them to a PWM generator as
// single-cycle writes on sel/d. Commands with addr 0 are consumed silently.
// Optional macro PWM_RAMP_EN: compare writes slew one count per cycle from
// the last written compare value to the new target instead of jumping.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, drops all pending work
//   cmd_valid  in   upstream command valid
//   cmd_ready  out  FIFO not full; command taken on valid && ready
//   cmd_addr   in   target: 0 none, 1 cmp, 2 top, 3 cnt
//   cmd_data   in   value to write
//   sel        out  register select to PWM generator
//   d          out  load value to PWM generator
//   busy       out  FIFO non-empty or a ramp in progress
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | pop one command per cycle while the FIFO has entries
// RAMP    | stepping cur_cmp toward tgt one count per cycle, pops paused
// -----------------------------------------------------------------------------
module pwm_cmd_seq
    import pwm_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [1:0]  sel,
    output logic [15:0] d,
    output logic        busy
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] head_raw;
    pwm_cmd_t         head;

    seq_state_e  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] d_q, d_d;
    logic [15:0] cur_cmp_q, cur_cmp_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] ramp_step;
`ifdef PWM_RAMP_EN
    logic [15:0] head_step;
`endif

    pwm_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_addr, cmd_data}),
        .pop       (fifo_pop),
        .rd_data   (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head      = pwm_cmd_t'(head_raw);
    assign ramp_step = step_toward(cur_cmp_q, tgt_q);
`ifdef PWM_RAMP_EN
    // The first ramp step is emitted on the pop edge itself, so a target one
    // count away (or equal) completes without ever entering RAMP.
    assign head_step = step_toward(cur_cmp_q, head.data);
`endif

    // State register and output/datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_NONE;
            d_q       <= '0;
            cur_cmp_q <= '0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            d_q       <= d_d;
            cur_cmp_q <= cur_cmp_d;
            tgt_q     <= tgt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef PWM_RAMP_EN
                if (!fifo_empty && (head.addr == SEL_CMP) && (head_step != head.data)) begin
                    state_d = ST_RAMP;
                end
`endif
            end
            ST_RAMP: begin
                if (ramp_step == tgt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: pop control and the next write presented on sel/d.
    // Anything not explicitly written falls back to sel=0, d=0.
    always_comb begin
        fifo_pop  = 1'b0;
        sel_d     = SEL_NONE;
        d_d       = '0;
        cur_cmp_d = cur_cmp_q;
        tgt_d     = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (head.addr)
                        SEL_NONE: begin
                        end
                        SEL_CMP: begin
                            sel_d     = SEL_CMP;
`ifdef PWM_RAMP_EN
                            d_d       = head_step;
                            cur_cmp_d = head_step;
                            tgt_d     = head.data;
`else
                            d_d       = head.data;
                            cur_cmp_d = head.data;
`endif
                        end
                        default: begin
                            sel_d = head.addr;
                            d_d   = head.data;
                        end
                    endcase
                end
            end
            ST_RAMP: begin
                sel_d     = SEL_CMP;
                d_d       = ramp_step;
                cur_cmp_d = ramp_step;
            end
            default: begin
            end
        endcase
    end

    assign sel       = sel_q;
    assign d         = d_q;
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_cmd_seq.sv
module tb_pwm_cmd_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [15:0] cmd_data = 16'd0;
    logic        cmd_ready;
    logic [1:0]  sel;
    logic [15:0] d;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pwm_cmd_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .sel       (sel),
        .d         (d),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Commands wait in m_cmdq; once taken, a command is expanded into the
    // full list of writes it produces (m_pend), played out one per cycle.
    logic [17:0] m_cmdq[$];
    logic [17:0] m_pend[$];
    logic [15:0] m_cur = 16'd0;
    logic [1:0]  m_sel = 2'd0;
    logic [15:0] m_d   = 16'd0;

    function automatic void expand(input logic [17:0] c);
        logic [1:0]  a = c[17:16];
        logic [15:0] v = c[15:0];
        if (a == 2'd0) begin
            m_pend.push_back(18'd0);
        end else if (a == 2'd1) begin
`ifdef PWM_RAMP_EN
            if (v == m_cur) m_pend.push_back({2'd1, v});
            while (m_cur != v) begin
                m_cur = (v > m_cur) ? m_cur + 16'd1 : m_cur - 16'd1;
                m_pend.push_back({2'd1, m_cur});
            end
`else
            m_pend.push_back({2'd1, v});
`endif
            m_cur = v;
        end else begin
            m_pend.push_back(c);
        end
    endfunction

    always @(posedge clk) begin : model
        logic [17:0] w;
        logic        acc;
        if (rst) begin
            m_cmdq.delete();
            m_pend.delete();
            m_cur = 16'd0;
            m_sel = 2'd0;
            m_d   = 16'd0;
        end else begin
            acc = cmd_valid && (m_cmdq.size() < DEPTH);
            if (m_pend.size() == 0 && m_cmdq.size() > 0) expand(m_cmdq.pop_front());
            w = (m_pend.size() > 0) ? m_pend.pop_front() : 18'd0;
            m_sel = w[17:16];
            m_d   = w[15:0];
            if (acc) m_cmdq.push_back({cmd_addr, cmd_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_sel",   {30'd0, sel}, {30'd0, m_sel});
            check("model_d",     {16'd0, d},   {16'd0, m_d});
            check("model_busy",  {31'd0, busy}, {31'd0, (m_cmdq.size() > 0 || m_pend.size() > 0)});
            check("model_ready", {31'd0, cmd_ready}, {31'd0, (m_cmdq.size() < DEPTH)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        cmd_valid = 1'b0;
        cmd_addr  = 2'd0;
        cmd_data  = 16'd0;
    endtask

    task automatic push_cmd(input logic [1:0] a, input logic [15:0] v);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = v;
        @(posedge clk); #1;
    endtask

    task automatic send_hs(input logic [1:0] a, input logic [15:0] v);
        logic r;
        r = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = v;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk); #1;
            if (r) break;
        end
        check("hs_accept", {31'd0, r}, 32'd1);
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("drain", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_sel",   {30'd0, sel}, 32'd0);
        check("rst_d",     {16'd0, d}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // single write latency and one-cycle hold
        push_cmd(2'd2, 16'h0009);
        idle_in();
        @(negedge clk); check("lat_pre_sel", {30'd0, sel}, 32'd0);
        @(negedge clk); check("lat_sel", {30'd0, sel}, 32'd2);
                        check("lat_d", {16'd0, d}, 32'd9);
        @(negedge clk); check("lat_after_sel", {30'd0, sel}, 32'd0);
                        check("lat_after_d", {16'd0, d}, 32'd0);

        // addr 0 discarded as an idle cycle
        push_cmd(2'd0, 16'hFFFF);
        push_cmd(2'd3, 16'h0002);
        idle_in();
        @(negedge clk); check("nop_sel", {30'd0, sel}, 32'd0);
                        check("nop_d", {16'd0, d}, 32'd0);
        @(negedge clk); check("cnt_sel", {30'd0, sel}, 32'd3);
                        check("cnt_d", {16'd0, d}, 32'd2);
        wait_idle();

        // cmp write then top write from cur_cmp = 0
        do_reset();
        push_cmd(2'd1, 16'd3);
        push_cmd(2'd2, 16'd7);
        idle_in();
`ifdef PWM_RAMP_EN
        @(negedge clk); check("ramp1_sel", {30'd0, sel}, 32'd1); check("ramp1_d", {16'd0, d}, 32'd1);
        @(negedge clk); check("ramp2_sel", {30'd0, sel}, 32'd1); check("ramp2_d", {16'd0, d}, 32'd2);
        @(negedge clk); check("ramp3_sel", {30'd0, sel}, 32'd1); check("ramp3_d", {16'd0, d}, 32'd3);
`else
        @(negedge clk); check("cmp_sel", {30'd0, sel}, 32'd1); check("cmp_d", {16'd0, d}, 32'd3);
`endif
        @(negedge clk); check("top_sel", {30'd0, sel}, 32'd2); check("top_d", {16'd0, d}, 32'd7);
        wait_idle();

        // back-to-back commands behind a long compare write
        do_reset();
        push_cmd(2'd1, 16'd20);
        send_hs(2'd2, 16'h0011);
        send_hs(2'd1, 16'd18);
        send_hs(2'd3, 16'h0033);
        send_hs(2'd0, 16'h1234);
`ifdef PWM_RAMP_EN
        @(negedge clk); check("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
`endif
        send_hs(2'd1, 16'd20);
        wait_idle();

        // reset with a compare in flight and two commands queued
        do_reset();
        push_cmd(2'd1, 16'd5);
        push_cmd(2'd2, 16'd1);
        push_cmd(2'd3, 16'd1);
        idle_in();
`ifdef PWM_RAMP_EN
        check("mid_sel", {30'd0, sel}, 32'd1);
        check("mid_d", {16'd0, d}, 32'd2);
`else
        check("mid_sel", {30'd0, sel}, 32'd2);
        check("mid_d", {16'd0, d}, 32'd1);
`endif
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sel", {30'd0, sel}, 32'd0);
        check("post_rst_d", {16'd0, d}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {14'd0, sel, d}, 32'd0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_seq.md
PWM_CMD_SEQ -- requirements
Module: pwm_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  upstream command valid.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 SHALL have port cmd_addr  input  2  target: 0 none, 1 cmp, 2 top, 3 cnt.
REQ-007 SHALL have port cmd_data  input  16  value to write.
REQ-008 SHALL have port sel  output  2  register select to PWM generator (same encoding as cmd_addr).
REQ-009 SHALL have port d  output  16  load value to PWM generator.
REQ-010 SHALL have port busy  output  1  high while FIFO non-empty or state != IDLE.

Function
REQ-011 SHALL drive cmd_ready = !full; no push when full, even if a pop occurs the same cycle.
REQ-012 SHALL, while in IDLE with FIFO non-empty, pop one entry per edge.
REQ-013 SHALL register sel/d: on the pop edge, sel<=addr, d<=data; so a command accepted at edge t is visible after edge t+1 and is sampled by the generator at edge t+2 (FIFO empty beforehand).
REQ-014 SHALL hold each write on sel/d for exactly one cycle, then return to sel=0, d=0 unless another write follows back-to-back.
REQ-015 SHALL pop and discard addr 0 commands, with sel=0 and d=0 for that cycle.
REQ-016 SHALL sustain back-to-back pops: N queued commands emit N consecutive writes.
REQ-017 SHALL track cur_cmp (16 bit), the last cmp value written on sel/d.
REQ-018 SHALL have states IDLE and RAMP; RAMP is reachable only per REQ-023.
REQ-019 SHALL compute all arithmetic in 16-bit unsigned with no wrap; ramp steps never cross the target.

Reset
REQ-020 SHALL, with rst high at an edge, empty the FIFO, set sel=0, d=0, cur_cmp=0, state=IDLE, busy=0, cmd_ready=1, and accept no command that edge.
REQ-021 SHALL, on rst mid-ramp or with a non-empty FIFO, drop all pending work; nothing is emitted after reset until new commands are accepted.

Configuration
REQ-022 SHALL, without PWM_RAMP_EN, write cmp commands directly like top/cnt (single cycle).
REQ-023 SHALL, with PWM_RAMP_EN, on popping a cmp command whose target != cur_cmp, enter RAMP; each cycle emit sel=1 with d=cur_cmp+1 or cur_cmp-1 toward the target; pause pops; return to IDLE on the cycle target is emitted; target == cur_cmp emits one write, no RAMP.

Structure
REQ-024 SHALL take sel encoding enum (SEL_NONE, SEL_CMP, SEL_TOP, SEL_CNT), command struct {addr, data} and FIFO_DEPTH default from shared package pwm_pkg.
REQ-025 SHALL instantiate one sub-module, pwm_cmd_fifo (synchronous FIFO with push/pop/full/empty, sync reset).

Verification
REQ-026 SHALL cover: push {2,0x0009} at edge t -> sel=2,d=9 after edge t+1 only, sel=0 the cycle after.
REQ-027 SHALL cover: 5 back-to-back commands with FIFO_DEPTH=4 and sel/d busy -> cmd_ready low after 4 accepted; all 5 emitted in order.
REQ-028 SHALL cover: {0,0xFFFF} then {3,0x0002} -> one idle cycle (sel=0,d=0) then sel=3,d=2.
REQ-029 SHALL cover: PWM_RAMP_EN, cur_cmp=0, cmd {1,3} then {2,7} -> sel=1 with d=1,2,3 on consecutive cycles, then sel=2,d=7; without macro -> sel=1,d=3 then sel=2,d=7.
REQ-030 SHALL cover: rst asserted mid-ramp at cur_cmp=2 toward 5 with 2 queued entries -> next cycle sel=0, d=0, busy=0, cmd_ready=1, no further writes.
